// File: rtl/adder_4bit_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit adder between two clients.
// Results are routed back by a {valid,id} tag pipeline and held until acked.
module adder_4bit_arbiter #(
  parameter int ADD_LATENCY = 1
) (
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       iREQ0_VALID,
  input  logic [3:0] iREQ0_A,
  input  logic [3:0] iREQ0_B,
  output logic       oREQ0_READY,
  output logic       oRES0_VALID,
  output logic [4:0] oRES0_DATA,
  input  logic       iRES0_ACK,
  input  logic       iREQ1_VALID,
  input  logic [3:0] iREQ1_A,
  input  logic [3:0] iREQ1_B,
  output logic       oREQ1_READY,
  output logic       oRES1_VALID,
  output logic [4:0] oRES1_DATA,
  input  logic       iRES1_ACK,
  output logic [3:0] oADD_A,
  output logic [3:0] oADD_B,
  output logic       oADD_ISSUE,
  input  logic [3:0] iADD_DATA,
  input  logic       iADD_C
);
  localparam int STAGES = ADD_LATENCY;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [1:0]      w_req_valid, w_res_ack, w_elig, w_grant, w_capture, w_res_valid;
  logic [1:0][3:0] w_req_a, w_req_b;
  logic [1:0][4:0] r_res_data;
  logic            w_any_grant, w_gid;
  logic            r_ptr;
  logic [3:0]      r_add_a, r_add_b;
  // Bit 0 is the issue register itself; bit STAGES lines up with adder output.
  logic [STAGES:0] r_vld_pipe, r_id_pipe;

  assign w_req_valid = {iREQ1_VALID, iREQ0_VALID};
  assign w_res_ack   = {iRES1_ACK, iRES0_ACK};
  assign w_req_a     = {iREQ1_A, iREQ0_A};
  assign w_req_b     = {iREQ1_B, iREQ0_B};

  // Grants never depend on acks and are suppressed while reset is high.
  assign w_grant[0]  = !iRESET_SYNC && w_elig[0] && (!w_elig[1] || !r_ptr);
  assign w_grant[1]  = !iRESET_SYNC && w_elig[1] && (!w_elig[0] ||  r_ptr);
  assign w_any_grant = |w_grant;
  assign w_gid       = w_grant[1];

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_ptr      <= 1'b0;
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      if (w_any_grant) r_ptr <= ~w_gid;
      r_add_a    <= w_any_grant ? w_req_a[w_gid] : 4'h0;
      r_add_b    <= w_any_grant ? w_req_b[w_gid] : 4'h0;
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_any_grant};
      r_id_pipe  <= {r_id_pipe[STAGES-1:0], w_gid};
    end
  end

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_client
      state_t r_state, w_state_nxt;
      logic   w_is_idle, w_is_done;

      assign w_capture[g] = r_vld_pipe[STAGES] && (r_id_pipe[STAGES] == 1'(g));

      always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
      end

      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          S_IDLE:  if (w_grant[g])   w_state_nxt = S_BUSY;
          S_BUSY:  if (w_capture[g]) w_state_nxt = S_DONE;
          S_DONE:  if (w_res_ack[g]) w_state_nxt = S_IDLE;
          default: w_state_nxt = S_IDLE;
        endcase
      end

      always_comb begin
        w_is_idle = 1'b0;
        w_is_done = 1'b0;
        case (r_state)
          S_IDLE:  w_is_idle = 1'b1;
          S_DONE:  w_is_done = 1'b1;
          default: ;
        endcase
      end

      assign w_elig[g]      = w_req_valid[g] && w_is_idle;
      assign w_res_valid[g] = w_is_done;

      always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC)        r_res_data[g] <= '0;
        else if (w_capture[g])  r_res_data[g] <= {iADD_C, iADD_DATA};
      end
    end
  endgenerate

  assign oREQ0_READY = w_grant[0];
  assign oREQ1_READY = w_grant[1];
  assign oRES0_VALID = w_res_valid[0];
  assign oRES1_VALID = w_res_valid[1];
  assign oRES0_DATA  = r_res_data[0];
  assign oRES1_DATA  = r_res_data[1];
  assign oADD_A      = r_add_a;
  assign oADD_B      = r_add_b;
  assign oADD_ISSUE  = r_vld_pipe[0];
endmodule

// File: doc/adder_4bit_arbiter.md
# adder_4bit_arbiter

Two-requester round-robin arbiter that shares one registered `adder_4bit` instance between two independent clients. Each client issues 4-bit operand pairs through a valid/ready handshake. The arbiter registers the winning operands into the adder and tracks the in-flight operation with a tag pipeline. It returns the 5-bit result (carry + sum) to the owning client, where the result is held until acknowledged. It sits between client logic and the `adder_4bit` instance in the top-level design.

## Interface
- `ADD_LATENCY`, default 1: cycles from adder operand inputs to valid adder output (`adder_4bit` registers its output). Legal range is 1–4.
- `iCLOCK` in 1: sole clock, rising edge.
- `iRESET_SYNC` in 1: reset, synchronous and active-high.
- `iREQ0_VALID` in 1: client 0 has an operand pair.
- `iREQ0_A`, `iREQ0_B` in 4 each: client 0 operands.
- `oREQ0_READY` out 1: client 0 request accepted this cycle (grant).
- `oRES0_VALID` out 1: client 0 result available; held until acked.
- `oRES0_DATA` out 5: client 0 result, {carry, sum}.
- `iRES0_ACK` in 1: client 0 consumes its result.
- `iREQ1_*`, `oREQ1_READY`, `oRES1_*`, `iRES1_ACK`: identical set for client 1.
- `oADD_A`, `oADD_B` out 4 each: registered operands to the adder.
- `oADD_ISSUE` out 1: `oADD_A`/`oADD_B` carry a live operation this cycle.
- `iADD_DATA` in 4: adder sum output.
- `iADD_C` in 1: adder carry output.

## Operation
- Each client has a 3-state FSM:
  - IDLE: can be granted.
  - BUSY: operation in flight.
  - DONE: result held.
- Transitions:
  - IDLE→BUSY on grant.
  - BUSY→DONE when its tag exits the tag pipeline.
  - DONE→IDLE on `iRESn_ACK`.
- Each client has at most one outstanding operation, so at most 2 operations are in flight.
- Eligible means `iREQn_VALID` is high and the client FSM is IDLE.
- Grant rule:
  - One eligible client: that client is granted.
  - Both eligible: the client indicated by the 1-bit priority pointer wins.
  - At most one grant per cycle. `oREQn_READY` is asserted only for the granted client.
- After any grant, the pointer moves to the non-granted client.
- `oREQn_READY` is a combinational function of `iREQ*_VALID`, FSM state and the pointer. It never depends on `iRES*_ACK` in the same cycle.
- On grant, the operands are registered into `oADD_A`/`oADD_B`, and `oADD_ISSUE` is set for one cycle. When there is no issue, `oADD_A`/`oADD_B`/`oADD_ISSUE` are driven to 0.
- Tag pipeline: `ADD_LATENCY` stages of {valid, id}, loaded alongside the issue register. The last stage's valid qualifies the capture of {`iADD_C`, `iADD_DATA`} into `oRESid_DATA`.
- The capture sets `oRESid_VALID`. `oRESn_DATA` is stable while `oRESn_VALID` is high.
- `iRESn_ACK` while `oRESn_VALID` is low is ignored.
- Arithmetic is performed by the adder only; the arbiter never modifies data. Result = A + B, a 5-bit zero-extended sum.
- Reset:
  - All FSMs go to IDLE, the pointer to 0, and all tag stages to invalid.
  - All outputs go to 0: `oREQn_READY`, `oRESn_VALID`, `oRESn_DATA`, `oADD_*`.
  - In-flight operations are discarded; adder outputs arriving after reset are ignored.
  - Requests are not granted during a reset cycle.

## Timing
- Grant at cycle T (`iREQn_VALID` and `oREQn_READY` both high at the edge ending T).
- `oADD_ISSUE`/operands are valid in T+1.
- Adder output is sampled at the end of T+ADD_LATENCY+1.
- `oRESn_VALID` goes high in T+ADD_LATENCY+2, i.e. T+3 for the default.
- Ack sampled at the end of cycle U → `oRESn_VALID` is low in U+1. The client can be granted in U+1 at the earliest.
- Throughput: one issue per cycle overall. Each client is limited to one operation per ack round trip.
- Both clients are eligible in the same cycle: the loser stays eligible and is granted the next cycle, provided it still holds valid.
- Simultaneous result capture for client n and ack of client m≠n: both take effect independently.

## Test plan
- Single request, default latency: client 0 requests A=3, B=4 at T → `oREQ0_READY` high at T, `oADD_ISSUE` with 3/4 at T+1, `oRES0_VALID` with DATA=5'h07 at T+3, held until ack.
- Overflow: A=4'hF, B=4'h1 → `oRES*_DATA`=5'h10. A=4'hF, B=4'hF → 5'h1E.
- Contention after reset: both clients valid every cycle → client 0 granted first, client 1 the next cycle. Results are 0+1→client 0 and 2+2→client 1, each routed to the correct client.
- No-ack hold: client 1 result not acked for 10 cycles → `oRES1_VALID`/DATA stable, `oREQ1_READY` low throughout, and client 0 is still served.
- Reset mid-flight: assert `iRESET_SYNC` one cycle after a grant → all outputs 0 and `oRES*_VALID` never asserts for that operation. A new request after reset completes normally.
- `ADD_LATENCY`=3 build: grant at T → `oRESn_VALID` at T+5 with the correct data. Back-to-back alternating grants keep tags in order.
